pipelined_rca: RTL and testbench

// - Parametrised, pipelined successor to the gate-level ripple-carry adder.
// - Splits an N-bit add/subtract into STAGES chunks of N/STAGES bits; each chunk is one

---
 rtl/pipelined_rca_pkg.sv | 13 +
 rtl/pipelined_rca_if.sv | 26 ++
 rtl/pipelined_rca_chunk.sv | 26 ++
 rtl/pipelined_rca.sv | 106 ++++++++++
 tb/tb_pipelined_rca.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pipelined_rca_pkg.sv
// rtl/pipelined_rca_pkg.sv - shared mode encoding and chunk-width helper for the pipelined adder
package pipelined_rca_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } op_mode_e;

    function automatic int chunk_width(input int n, input int stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// rtl/pipelined_rca_if.sv - operand/result handshake bundle for the pipelined adder
interface pipelined_rca_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_rca_chunk.sv
// rtl/pipelined_rca_chunk.sv - combinational W-bit ripple-carry chunk
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);
    logic carry;

    // c_msb_in is the carry entering the top bit, needed for signed overflow.
    always_comb begin
        carry    = cin;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) c_msb_in = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - N-bit add/sub split into STAGES registered ripple chunks
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pipelined_rca_if.slave bus
);
    localparam int W   = chunk_width(N, STAGES);
    localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

    generate
        if (N % STAGES != 0) begin : g_bad_split
            $error("pipelined_rca: N must be a multiple of STAGES");
        end
    endgenerate

    logic         stall;
    logic [N-1:0] b_eff;
    logic         cin_eff;

    logic         valid_q [STAGES];
    logic         carry_q [STAGES];
    logic [N-1:0] res_q   [STAGES];
    logic         ovf_q;
    logic [N-1:0] opa_q   [OPS];
    logic [N-1:0] opb_q   [OPS];

    logic [W-1:0] ch_a    [STAGES];
    logic [W-1:0] ch_b    [STAGES];
    logic [W-1:0] ch_sum  [STAGES];
    logic         ch_cin  [STAGES];
    logic         ch_cout [STAGES];
    logic         ch_cmsb [STAGES];

    assign stall        = valid_q[STAGES-1] && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign b_eff        = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
    assign cin_eff      = (bus.sub == MODE_SUB) ? 1'b1 : bus.carry_in;

    // Chunk 0 reads the live operands; later chunks read operands carried down the pipe.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_chunk
            if (k == 0) begin : g_first
                assign ch_a[k]   = bus.a[W-1:0];
                assign ch_b[k]   = b_eff[W-1:0];
                assign ch_cin[k] = cin_eff;
            end else begin : g_rest
                assign ch_a[k]   = opa_q[k-1][k*W +: W];
                assign ch_b[k]   = opb_q[k-1][k*W +: W];
                assign ch_cin[k] = carry_q[k-1];
            end

            rca_chunk #(.W(W)) u_chunk (
                .a        (ch_a[k]),
                .b        (ch_b[k]),
                .cin      (ch_cin[k]),
                .sum      (ch_sum[k]),
                .cout     (ch_cout[k]),
                .c_msb_in (ch_cmsb[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                res_q[k]   <= '0;
            end
            for (int k = 0; k < OPS; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            valid_q[0] <= bus.in_valid;
            carry_q[0] <= ch_cout[0];
            res_q[0]   <= N'(ch_sum[0]);
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k]             <= valid_q[k-1];
                carry_q[k]             <= ch_cout[k];
                res_q[k]               <= res_q[k-1];
                res_q[k][k*W +: W]     <= ch_sum[k];
            end
            if (STAGES > 1) begin
                opa_q[0] <= bus.a;
                opb_q[0] <= b_eff;
            end
            for (int k = 1; k < OPS; k++) begin
                opa_q[k] <= opa_q[k-1];
                opb_q[k] <= opb_q[k-1];
            end
            ovf_q <= ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = res_q[STAGES-1];
    assign bus.carry_out = carry_q[STAGES-1];
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - directed self-checking bench for pipelined_rca (8/2 and 16/4)
`timescale 1ns/1ps
module tb_pipelined_rca;
    import pipelined_rca_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipelined_rca_if #(.N(8))  if8 ();
    pipelined_rca_if #(.N(16)) if16 ();

    pipelined_rca #(.N(8),  .STAGES(2)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    pipelined_rca #(.N(16), .STAGES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    logic [7:0] st_a [4] = '{8'h01, 8'h10, 8'hFF, 8'h40};
    logic [7:0] st_b [4] = '{8'h02, 8'h20, 8'hFF, 8'h40};
    logic [7:0] st_s [4] = '{8'h03, 8'h30, 8'hFE, 8'h80};
    logic       st_c [4] = '{1'b0,  1'b0,  1'b1,  1'b0};
    logic       st_v [4] = '{1'b0,  1'b0,  1'b0,  1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb);
        if8.in_valid = v;
        if8.a        = av;
        if8.b        = bv;
        if8.carry_in = ci;
        if8.sub      = sb;
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                       input logic [7:0] es, input logic ec, input logic ev, input string tag);
        if8.out_ready = 1'b1;
        drive8(1'b1, av, bv, ci, sb);
        tick();
        if8.in_valid = 1'b0;
        chk({tag, "_lat1"}, if8.out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, if8.out_valid, 1'b1);
        chk({tag, "_sum"},   if8.sum, es);
        chk({tag, "_cout"},  if8.carry_out, ec);
        chk({tag, "_ovf"},   if8.overflow, ev);
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sb,
                        input logic [15:0] es, input logic ec, input logic ev, input string tag);
        if16.out_ready = 1'b1;
        if16.in_valid  = 1'b1;
        if16.a         = av;
        if16.b         = bv;
        if16.carry_in  = 1'b0;
        if16.sub       = sb;
        tick();
        if16.in_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_lat3"}, if16.out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, if16.out_valid, 1'b1);
        chk({tag, "_sum"},   if16.sum, es);
        chk({tag, "_cout"},  if16.carry_out, ec);
        chk({tag, "_ovf"},   if16.overflow, ev);
    endtask

    initial begin
        rst = 1'b1;
        drive8(1'b0, 8'h00, 8'h00, 1'b0, MODE_ADD);
        if8.out_ready  = 1'b1;
        if16.in_valid  = 1'b0;
        if16.a         = '0;
        if16.b         = '0;
        if16.carry_in  = 1'b0;
        if16.sub       = MODE_ADD;
        if16.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst8_out_valid",  if8.out_valid, 1'b0);
        chk("rst8_sum",        if8.sum, 8'h00);
        chk("rst8_cout",       if8.carry_out, 1'b0);
        chk("rst8_ovf",        if8.overflow, 1'b0);
        chk("rst8_in_ready",   if8.in_ready, 1'b1);
        chk("rst16_out_valid", if16.out_valid, 1'b0);
        chk("rst16_sum",       if16.sum, 16'h0000);

        op8(8'hFF, 8'h01, 1'b0, MODE_ADD, 8'h00, 1'b1, 1'b0, "add_ff_01");
        op8(8'h0F, 8'h01, 1'b0, MODE_ADD, 8'h10, 1'b0, 1'b0, "add_0f_01");
        op8(8'h7F, 8'h01, 1'b0, MODE_ADD, 8'h80, 1'b0, 1'b1, "add_7f_01");
        op8(8'h10, 8'h20, 1'b1, MODE_ADD, 8'h31, 1'b0, 1'b0, "add_cin");
        op8(8'h05, 8'h07, 1'b0, MODE_SUB, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        op8(8'h05, 8'h07, 1'b1, MODE_SUB, 8'hFE, 1'b0, 1'b0, "sub_cin_ignored");
        op8(8'h80, 8'h01, 1'b0, MODE_SUB, 8'h7F, 1'b1, 1'b1, "sub_80_01");

        if8.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive8(1'b1, st_a[i], st_b[i], 1'b0, MODE_ADD);
            else       if8.in_valid = 1'b0;
            chk("stream_in_ready", if8.in_ready, 1'b1);
            tick();
            if (i >= 1 && i <= 4) begin
                chk("stream_valid", if8.out_valid, 1'b1);
                chk("stream_sum",   if8.sum, st_s[i-1]);
                chk("stream_cout",  if8.carry_out, st_c[i-1]);
                chk("stream_ovf",   if8.overflow, st_v[i-1]);
            end else begin
                chk("stream_idle", if8.out_valid, 1'b0);
            end
        end

        drive8(1'b1, 8'h12, 8'h34, 1'b0, MODE_ADD);
        tick();
        drive8(1'b1, 8'hAB, 8'h01, 1'b0, MODE_ADD);
        if8.out_ready = 1'b0;
        tick();
        drive8(1'b1, 8'h01, 8'h01, 1'b0, MODE_ADD);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", if8.in_ready, 1'b0);
            chk("stall_valid",    if8.out_valid, 1'b1);
            chk("stall_sum",      if8.sum, 8'h46);
            chk("stall_cout",     if8.carry_out, 1'b0);
            tick();
        end
        chk("stall_hold_sum", if8.sum, 8'h46);
        if8.out_ready = 1'b1;
        #1;
        chk("release_in_ready", if8.in_ready, 1'b1);
        tick();
        if8.in_valid = 1'b0;
        chk("release_y_valid", if8.out_valid, 1'b1);
        chk("release_y_sum",   if8.sum, 8'hAC);
        tick();
        chk("release_z_valid", if8.out_valid, 1'b1);
        chk("release_z_sum",   if8.sum, 8'h02);
        tick();
        chk("release_drained", if8.out_valid, 1'b0);

        drive8(1'b1, 8'h01, 8'h01, 1'b0, MODE_ADD);
        tick();
        drive8(1'b1, 8'h02, 8'h02, 1'b0, MODE_ADD);
        tick();
        if8.in_valid = 1'b0;
        chk("pre_rst_valid", if8.out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_valid",    if8.out_valid, 1'b0);
        chk("flush_sum",      if8.sum, 8'h00);
        chk("flush_cout",     if8.carry_out, 1'b0);
        chk("flush_ovf",      if8.overflow, 1'b0);
        chk("flush_in_ready", if8.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_stale", if8.out_valid, 1'b0);
        end

        op16(16'hFFFF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0, "w16_add_ffff_1");
        op16(16'h000F, 16'h0001, MODE_ADD, 16'h0010, 1'b0, 1'b0, "w16_add_000f_1");
        op16(16'h00FF, 16'h0001, MODE_ADD, 16'h0100, 1'b0, 1'b0, "w16_add_00ff_1");
        op16(16'h7FFF, 16'h0001, MODE_ADD, 16'h8000, 1'b0, 1'b1, "w16_add_7fff_1");
        op16(16'h0005, 16'h0007, MODE_SUB, 16'hFFFE, 1'b0, 1'b0, "w16_sub_5_7");
        op16(16'h8000, 16'h0001, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, "w16_sub_8000_1");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
